// File: rtl/hamming_gen.sv
// Emits an N-bit vector with kk = min(count, N) ones placed LSB-first, as CC chunks of M bits.
// Optional macro HAMMING_GEN_XOR_EN XORs each loaded chunk with g_input so that the distance to g equals kk.
module hamming_gen #(
  parameter int N  = 8,
  parameter int CC = 1,
  localparam int M  = N / CC,
  localparam int CW = $clog2(N + 1),
  localparam int IW = $clog2(CC + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] count,
  input  logic [M-1:0]  g_input,
  input  logic          o_ready,
  output logic [M-1:0]  o,
  output logic          o_valid,
  output logic          o_last,
  output logic          busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CW-1:0] N_VAL    = CW'(N);
  localparam logic [CW-1:0] M_VAL    = CW'(M);
  localparam logic [IW-1:0] LAST_IDX = IW'(CC - 1);

  state_t        state;
  logic [CW-1:0] rem;
  logic [IW-1:0] idx;

  logic [CW-1:0] kk;
  logic [CW-1:0] step_kk;
  logic [CW-1:0] step_rem;
  logic [M-1:0]  chunk_kk;
  logic [M-1:0]  chunk_rem;
  logic [M-1:0]  g_mask;

  assign kk       = (count > N_VAL) ? N_VAL : count;
  assign step_kk  = (kk > M_VAL) ? M_VAL : kk;
  assign step_rem = (rem > M_VAL) ? M_VAL : rem;

  // Thermometer chunk: bit i is set while more than i ones remain to be placed.
  for (genvar gi = 0; gi < M; gi++) begin : g_chunk
    assign chunk_kk[gi]  = (kk > CW'(gi));
    assign chunk_rem[gi] = (rem > CW'(gi));
  end

`ifdef HAMMING_GEN_XOR_EN
  assign g_mask = g_input;
`else
  logic g_unused;
  assign g_unused = ^g_input;
  assign g_mask   = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      o       <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      busy    <= 1'b0;
      rem     <= '0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            o       <= chunk_kk ^ g_mask;
            o_valid <= 1'b1;
            o_last  <= (CC == 1);
            busy    <= 1'b1;
            rem     <= kk - step_kk;
            idx     <= IW'(1);
            state   <= RUN;
          end
        end
        RUN: begin
          // Without o_ready everything holds; start is never queued here.
          if (o_ready) begin
            if (o_last) begin
              o       <= '0;
              o_valid <= 1'b0;
              o_last  <= 1'b0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              o      <= chunk_rem ^ g_mask;
              rem    <= rem - step_rem;
              o_last <= (idx == LAST_IDX);
              idx    <= idx + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hamming_gen.sv
// Drives a CC=1 and a CC=4 instance with the same stimulus and checks both against a vector-level model.
module tb_hamming_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       ready = 1'b0;
  logic [3:0] count = '0;
  logic [7:0] g = '0;

  logic [7:0] o1;
  logic       v1, l1, b1;
  logic [1:0] o4;
  logic       v4, l4, b4;

  int vectors = 0;
  int miscompares = 0;

  // Model state per instance: d=0 is CC=1, d=1 is CC=4.
  bit         m_busy [2];
  int         m_j    [2];
  int         m_e    [2];
  logic [7:0] m_o    [2];

  hamming_gen #(.N(8), .CC(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .count(count), .g_input(g),
    .o_ready(ready), .o(o1), .o_valid(v1), .o_last(l1), .busy(b1)
  );

  hamming_gen #(.N(8), .CC(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .count(count), .g_input(g[1:0]),
    .o_ready(ready), .o(o4), .o_valid(v4), .o_last(l4), .busy(b4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_busy[d] = 1'b0;
      m_j[d]    = 0;
      m_e[d]    = 0;
      m_o[d]    = '0;
    end
  endtask

  // The target vector is simply (2^kk)-1; chunk j is its j-th M-bit field.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int cc   = (d == 0) ? 1 : 4;
      int mm   = (d == 0) ? 8 : 2;
      int mask = (1 << mm) - 1;
      int gx;
      int kk;
`ifdef HAMMING_GEN_XOR_EN
      gx = int'(g) & mask;
`else
      gx = 0;
`endif
      if (!m_busy[d]) begin
        if (start) begin
          kk        = (int'(count) > 8) ? 8 : int'(count);
          m_e[d]    = (1 << kk) - 1;
          m_j[d]    = 0;
          m_o[d]    = 8'((m_e[d] & mask) ^ gx);
          m_busy[d] = 1'b1;
        end
      end else if (ready) begin
        if (m_j[d] == cc - 1) begin
          m_busy[d] = 1'b0;
          m_o[d]    = '0;
        end else begin
          m_j[d] = m_j[d] + 1;
          m_o[d] = 8'(((m_e[d] >> (m_j[d] * mm)) & mask) ^ gx);
        end
      end
    end
  endtask

  task automatic check_all();
    logic [7:0] ob [2];
    logic       ov [2];
    logic       ol [2];
    logic       obz[2];
    ob[0] = o1;           ov[0] = v1; ol[0] = l1; obz[0] = b1;
    ob[1] = {6'b0, o4};   ov[1] = v4; ol[1] = l4; obz[1] = b4;
    for (int d = 0; d < 2; d++) begin
      int cc = (d == 0) ? 1 : 4;
      chk($sformatf("cc%0d_o", cc), ob[d], m_o[d]);
      chk($sformatf("cc%0d_valid", cc), {7'b0, ov[d]}, {7'b0, m_busy[d]});
      chk($sformatf("cc%0d_last", cc), {7'b0, ol[d]}, {7'b0, (m_busy[d] && m_j[d] == cc - 1)});
      chk($sformatf("cc%0d_busy", cc), {7'b0, obz[d]}, {7'b0, m_busy[d]});
    end
  endtask

  task automatic cycle();
    if (rst) model_edge();
    else model_reset();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [7:0] exp_xor;

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 1'b1;

    // Basic CC=1 with g=A5: the ones vector 07, XOR-ed only when the feature is built in
`ifdef HAMMING_GEN_XOR_EN
    exp_xor = 8'hA2;
`else
    exp_xor = 8'h07;
`endif
    g = 8'hA5; count = 4'd3; start = 1'b1; ready = 1'b1;
    cycle();
    start = 1'b0;
    chk("basic_o", o1, exp_xor);
    chk("basic_valid", {7'b0, v1}, 8'h01);
    chk("basic_last", {7'b0, l1}, 8'h01);
    chk("basic_busy", {7'b0, b1}, 8'h01);
    cycle();
    chk("basic_done_valid", {7'b0, v1}, 8'h00);
    chk("basic_done_busy", {7'b0, b1}, 8'h00);
    repeat (3) cycle();
    g = 8'h00;

    // Chunked CC=4, count=5
    count = 4'd5; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("k5_c0", {6'b0, o4}, 8'h03);
    chk("k5_c0_last", {7'b0, l4}, 8'h00);
    cycle(); chk("k5_c1", {6'b0, o4}, 8'h03);
    cycle(); chk("k5_c2", {6'b0, o4}, 8'h01);
    cycle(); chk("k5_c3", {6'b0, o4}, 8'h00);
    chk("k5_c3_last", {7'b0, l4}, 8'h01);
    cycle(); chk("k5_end_valid", {7'b0, v4}, 8'h00);

    // count=0 still emits four zero chunks
    count = 4'd0; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("k0_c0", {6'b0, o4}, 8'h00);
    chk("k0_c0_valid", {7'b0, v4}, 8'h01);
    repeat (3) cycle();
    chk("k0_c3_last", {7'b0, l4}, 8'h01);
    cycle();

    // Saturation
    count = 4'd12; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("sat_o", o1, 8'hFF);
    repeat (4) cycle();

    // Backpressure with an ignored start in RUN
    count = 4'd8; start = 1'b1; ready = 1'b1;
    cycle();
    start = 1'b0; ready = 1'b0;
    chk("bp_c0", {6'b0, o4}, 8'h03);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("bp_hold1", {6'b0, o4}, 8'h03);
    chk("bp_hold1_valid", {7'b0, v4}, 8'h01);
    cycle();
    chk("bp_hold2", {6'b0, o4}, 8'h03);
    ready = 1'b1;
    cycle(); chk("bp_c1", {6'b0, o4}, 8'h03);
    cycle(); chk("bp_c2", {6'b0, o4}, 8'h03);
    cycle(); chk("bp_c3", {6'b0, o4}, 8'h03);
    chk("bp_c3_last", {7'b0, l4}, 8'h01);
    cycle(); chk("bp_end_busy", {7'b0, b4}, 8'h00);

    // Reset mid-vector clears outputs without waiting for a clock edge
    count = 4'd5; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    rst = 1'b0;
    #2;
    model_reset();
    check_all();
    chk("rst_o", {6'b0, o4}, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b1;
    count = 4'd2; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("post_rst_c0", {6'b0, o4}, 8'h03);
    cycle(); chk("post_rst_c1", {6'b0, o4}, 8'h00);
    cycle(); chk("post_rst_c2", {6'b0, o4}, 8'h00);
    cycle(); chk("post_rst_c3", {6'b0, o4}, 8'h00);
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 2) == 0);
      count = 4'($urandom_range(0, 15));
      g     = 8'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hamming_gen.md
Name: hamming_gen

Overview:
- Inverse of the secure-computation hamming-distance block.
- Given a target distance k, produces an N-bit vector e with popcount(e XOR g) = k.
  - Without the optional feature: e has exactly k ones.
- Ones are placed LSB-first, and the vector is streamed out in M = N/CC-bit chunks over CC cycles, with valid/ready handshake and chunk-level backpressure.
- Feeds the distance counter's e_input path in self-test, and workload generation for garbled-circuit benches.

Parameters:
- N, 8, total vector width in bits.
- CC, 1, number of chunks (cycles) per vector; N divisible by CC; M = N/CC.
- Width function log2(v): number of bits needed to hold v (floor(log2 v)+1); 4 for N=8.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request a new vector; sampled only in IDLE.
- count  input  log2(N)  target distance k; sampled with start.
- g_input  input  M  reference chunk; sampled on each edge that loads o.
- o_ready  input  1  consumer accepts current chunk.
- o  output  M  current output chunk (registered).
- o_valid  output  1  o holds a valid chunk.
- o_last  output  1  current chunk is chunk CC-1.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE.
  - o=0, o_valid=0, o_last=0, busy=0; rem=0, idx=0.
  - A reset mid-vector aborts the vector with no partial completion.
- Saturation: kk = min(count, N). For N a power of 2, counts N+1..2N-1 become N.
- Chunk function for remaining value r: bit i (0..M-1) = 1 iff r > i.
- IDLE:
  - On start=1, load on that edge:
    - o ← chunk(kk), XOR-ed per Optional Feature.
    - o_valid=1, o_last=(CC==1).
    - rem = kk − min(kk, M), idx=1.
    - Go to RUN.
  - Latency: first chunk visible the cycle after start.
  - start=0: hold; all outputs stay 0.
- RUN, busy=1:
  - o_valid=1, o_ready=0: o, o_last, rem and idx all hold. g_input is not resampled.
  - o_ready=1, o_last=0:
    - o ← chunk(rem).
    - rem −= min(rem, M).
    - o_last=(idx==CC−1), idx++.
  - o_ready=1, o_last=1: o_valid=0, o=0, o_last=0, go to IDLE.
  - start in RUN is ignored and not queued.
  - start asserted on the same cycle the last chunk is accepted is ignored. The next vector needs start in IDLE, giving one bubble cycle between vectors.
- Throughput: one chunk per cycle with o_ready held high. A full vector takes CC cycles plus one IDLE cycle.
- Widths:
  - rem: log2(N) bits.
  - idx: log2(CC) bits, minimum 1.
  - rem never underflows, because min() guards the subtraction.
- Boundaries:
  - k=0 gives all-zero chunks; the vector is still emitted in full.
  - k=N gives all-ones chunks.
  - k an exact multiple of M: the chunks after the filled ones are zero.

Optional Feature:
- Macro: HAMMING_GEN_XOR_EN.
- Defined: each loaded chunk is chunk(r) XOR g_input. Then hamming(g, e) = kk over the full vector.
- Undefined: o = chunk(r). g_input is ignored and does not affect timing or state.

Test Plan:
- Basic, CC=1: N=8, count=3, start pulse, o_ready=1, macro off.
  - Next cycle: o=8'h07, o_valid=1, o_last=1, busy=1.
  - Following cycle: o_valid=0, busy=0.
- Chunked, CC=4 (M=2): count=5.
  - Chunks 2'b11, 2'b11, 2'b01, 2'b00 on four consecutive cycles.
  - o_last only on the fourth chunk.
  - count=0 yields four 2'b00 chunks.
- Saturation, CC=1: count=12 → o=8'hFF.
- Backpressure and ignored start, CC=4: count=8.
  - o_ready low for 2 cycles after the first chunk: o holds 2'b11 with o_valid=1.
  - A start pulse during RUN is ignored.
  - Remaining chunks 11, 11, 11 follow once o_ready is high.
- Reset mid-vector: rst low during chunk 2 → o=0, o_valid=0, busy=0 immediately. A fresh start with count=2 yields 2'b11, 00, 00, 00.
- XOR feature, CC=1: g_input=8'hA5, count=3.
  - Macro on: o=8'hA2.
  - Macro off: o=8'h07.
